// File: rtl/alu_exec_unit.sv
// Execution unit: single-cycle ALU ops, iterative shift-add MUL, optional DIV.
// Define ALU_DIV_EN to build the restoring divider for opcode 13.
module alu_exec_unit #(
  parameter int WIDTH = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enAlu,
  input  logic [3:0]         opcode,
  input  logic [WIDTH-1:0]   opA,
  input  logic [WIDTH-1:0]   opB,
  output logic [2*WIDTH-1:0] result,
  output logic               zero,
  output logic               carry,
  output logic               err,
  output logic               busy,
  output logic               done
);

  localparam int RW = 2 * WIDTH;
  localparam logic [3:0] LAST = 4'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MUL,
    S_DIV
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [RW-1:0]     acc_q, acc_d;
  logic [RW-1:0]     mc_q, mc_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [RW-1:0]     result_q, result_d;
  logic              zero_q, zero_d;
  logic              carry_q, carry_d;
  logic              err_q, err_d;
  logic              done_q, done_d;

  logic [WIDTH:0]    add_w, sub_w, shl_w;
  logic [WIDTH-1:0]  alu_n;
  logic [RW-1:0]     alu_res;
  logic              alu_c, alu_e;

  assign add_w = {1'b0, a_q} + {1'b0, b_q};
  assign sub_w = {1'b0, a_q} - {1'b0, b_q};
  assign shl_w = {1'b0, a_q} << b_q[2:0];

`ifdef ALU_DIV_EN
  logic [RW:0]      div_t;
  logic [WIDTH:0]   div_r;
  logic [WIDTH:0]   div_s;
  logic [RW-1:0]    div_nx;

  // One restoring step on the packed {remainder, quotient} accumulator
  assign div_t  = {acc_q, 1'b0};
  assign div_r  = div_t[RW:WIDTH];
  assign div_s  = div_r - {1'b0, b_q};
  assign div_nx = div_s[WIDTH] ? div_t[RW-1:0]
                               : {div_s[WIDTH-1:0], div_t[WIDTH-1:1], 1'b1};
`endif

  always_comb begin
    alu_n = '0;
    alu_c = 1'b0;
    alu_e = 1'b0;
    alu_res = '0;
    case (op_q)
      4'd0:  {alu_c, alu_n} = add_w;
      4'd1:  {alu_c, alu_n} = sub_w;
      4'd2:  alu_n = a_q & b_q;
      4'd3:  alu_n = a_q | b_q;
      4'd4:  alu_n = ~a_q;
      4'd5:  alu_n = a_q ^ b_q;
      4'd6:  {alu_c, alu_n} = shl_w;
      4'd7:  alu_n = -a_q;
      4'd8:  alu_n = a_q >> b_q[2:0];
      4'd9:  alu_n = ~(a_q & b_q);
      4'd10: alu_n = ~(a_q | b_q);
      4'd11: alu_n = ~(a_q ^ b_q);
`ifdef ALU_DIV_EN
      4'd13: alu_e = 1'b1;
`endif
      default: alu_e = 1'b1;
    endcase
    alu_res = {{WIDTH{1'b0}}, alu_n};
`ifdef ALU_DIV_EN
    // Only a zero divisor reaches the single-cycle path for opcode 13
    if (op_q == 4'd13) alu_res = '1;
`endif
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    mc_d     = mc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    err_d    = err_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (enAlu) begin
          op_d    = opcode;
          a_d     = opA;
          b_d     = opB;
          acc_d   = '0;
          mc_d    = {{WIDTH{1'b0}}, opA};
          cnt_d   = '0;
          state_d = S_EXEC;
          if (opcode == 4'd12) state_d = S_MUL;
`ifdef ALU_DIV_EN
          if (opcode == 4'd13 && opB != '0) begin
            state_d = S_DIV;
            acc_d   = {{WIDTH{1'b0}}, opA};
          end
`endif
        end
      end
      S_EXEC: begin
        result_d = alu_res;
        zero_d   = (alu_res == '0);
        carry_d  = alu_c;
        err_d    = alu_e;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      S_MUL: begin
        if (cnt_q == LAST) begin
          result_d = acc_q;
          zero_d   = (acc_q == '0);
          carry_d  = 1'b0;
          err_d    = 1'b0;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end else begin
          if (b_q[0]) acc_d = acc_q + mc_q;
          mc_d  = mc_q << 1;
          b_d   = b_q >> 1;
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DIV: begin
`ifdef ALU_DIV_EN
        if (cnt_q == LAST) begin
          result_d = acc_q;
          zero_d   = (acc_q == '0);
          carry_d  = 1'b0;
          err_d    = 1'b0;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end else begin
          acc_d = div_nx;
          cnt_d = cnt_q + 4'd1;
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      mc_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      mc_q     <= mc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign zero   = zero_q;
  assign carry  = carry_q;
  assign err    = err_q;
  assign done   = done_q;
  assign busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed spec cases plus random ops
// against an arithmetic reference model.
module tb_alu_exec_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enAlu = 1'b0;
  logic [3:0]  opcode = '0;
  logic [7:0]  opA = '0;
  logic [7:0]  opB = '0;
  logic [15:0] result;
  logic        zero, carry, err, busy, done;

  alu_exec_unit #(.WIDTH(8)) dut (
    .clock(clock), .reset(reset), .enAlu(enAlu),
    .opcode(opcode), .opA(opA), .opB(opB),
    .result(result), .zero(zero), .carry(carry),
    .err(err), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [15:0] res;
    logic        z;
    logic        c;
    logic        e;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  int   pushed = 0;
  int   mon_n  = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input int op, input int a, input int b);
    exp_t m;
    int r, s;
    bit c, e;
    r = 0; c = 0; e = 0;
    case (op)
      0: begin r = (a + b) % 256; c = (a + b) > 255; end
      1: begin r = (a - b + 256) % 256; c = a < b; end
      2: r = a & b;
      3: r = a | b;
      4: r = 255 - a;
      5: r = a ^ b;
      6: begin
        s = b % 8;
        r = (a << s) % 256;
        c = (s != 0) && (((a >> (8 - s)) & 1) == 1);
      end
      7: r = (256 - a) % 256;
      8: r = a >> (b % 8);
      9: r = 255 - (a & b);
      10: r = 255 - (a | b);
      11: r = 255 - (a ^ b);
      12: r = a * b;
`ifdef ALU_DIV_EN
      13: begin
        if (b == 0) begin r = 65535; e = 1; end
        else r = (a % b) * 256 + a / b;
      end
`endif
      default: e = 1;
    endcase
    m.res = r[15:0];
    m.z = (r == 0);
    m.c = c;
    m.e = e;
    return m;
  endfunction

  function automatic int exp_lat(input int op, input int b);
    if (op == 12) return 9;
`ifdef ALU_DIV_EN
    if (op == 13 && b != 0) return 9;
`endif
    return 1;
  endfunction

  always @(negedge clock) begin
    exp_t e;
    if (!reset && done) begin
      mon_n++;
      if (sbq.size() == 0) begin
        chk("unexpected done", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk("result", result, e.res);
        chk("zero", zero, e.z);
        chk("carry", carry, e.c);
        chk("err", err, e.e);
      end
    end
  end

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
  endtask

  task automatic issue(input int op, input int a, input int b);
    int lat;
    sbq.push_back(model(op, a, b));
    pushed++;
    @(negedge clock);
    enAlu = 1'b1; opcode = 4'(op); opA = 8'(a); opB = 8'(b);
    @(posedge clock); #1;
    enAlu = 1'b0;
    opA = 8'($urandom); opB = 8'($urandom); opcode = 4'($urandom);
    chk("busy after capture", busy, 1);
    wait_done(lat);
    chk("latency", lat, exp_lat(op, b));
  endtask

  initial begin
    int lat;
    #1;
    chk("reset result", result, 0);
    chk("reset flags", {zero, carry, err, busy, done}, 0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    issue(0, 8'hF0, 8'h20);
    issue(1, 5, 5);
    issue(1, 3, 5);
    issue(12, 8'hFF, 8'hFF);
    issue(6, 8'hA5, 3);
    issue(6, 8'h81, 0);
    issue(7, 0, 9);
    issue(13, 100, 7);
    issue(13, 55, 0);

    // Re-strobe during MUL must be ignored
    sbq.push_back(model(12, 8'h12, 8'h34));
    pushed++;
    @(negedge clock);
    enAlu = 1'b1; opcode = 4'd12; opA = 8'h12; opB = 8'h34;
    @(posedge clock); #1;
    enAlu = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    enAlu = 1'b1; opcode = 4'd0; opA = 8'h01; opB = 8'h01;
    @(posedge clock); #1;
    enAlu = 1'b0;
    wait_done(lat);
    chk("mul done seen", done, 1);
    repeat (4) @(posedge clock);
    issue(14, 8'h33, 8'h44);

    // Reset in the middle of a MUL
    @(negedge clock);
    enAlu = 1'b1; opcode = 4'd12; opA = 8'hC3; opB = 8'h5A;
    @(posedge clock); #1;
    enAlu = 1'b0;
    repeat (4) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    chk("rst result", result, 0);
    chk("rst flags", {zero, carry, err, busy, done}, 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (12) @(posedge clock);
    issue(12, 8'h0D, 8'h0B);

    for (int i = 0; i < 150; i++)
      issue($urandom_range(0, 15), $urandom_range(0, 255),
            $urandom_range(0, 255));

    repeat (3) @(posedge clock);
    chk("done count", mon_n, pushed);
    chk("scoreboard empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
